// File: rtl/if_stage.sv
// Instruction fetch: 1-cycle SRAM, 2-entry {pc,inst} queue, id_* visible 2 cycles after issue.
// Backpressure: issue stalls once queued plus in-flight would exceed 2; a taken branch flushes and refetches.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h1c000000,
  parameter logic [31:0] BUBBLE_PC = 32'h1bfffffc
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata,
  input  logic        id_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        fs_to_ds_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic [31:0] fetch_pc;
  logic        pend_q;
  logic [31:0] pend_pc;
  logic [1:0]  count;
  logic        head;
  logic        tail;
  entry_t      q [2];

  logic        pop;
  logic        redirect;
  logic        enq;
  logic [2:0]  occupancy;

  assign pop      = fs_to_ds_valid & id_allowin;
  assign redirect = br_taken & pop;
  assign enq      = pend_q & ~redirect;

  // Slots already owed: queued entries that stay plus the response still in flight.
  assign occupancy = {1'b0, count} + {2'b0, pend_q} - {2'b0, pop};

  assign inst_sram_en   = ~reset & (redirect | (occupancy < 3'd2));
  assign inst_sram_addr = redirect ? br_target : fetch_pc;

  assign fs_to_ds_valid = (count != 2'd0);
  assign id_pc          = fs_to_ds_valid ? q[head].pc   : BUBBLE_PC;
  assign id_inst        = fs_to_ds_valid ? q[head].inst : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      pend_q   <= 1'b0;
      pend_pc  <= RESET_PC;
      count    <= 2'd0;
      head     <= 1'b0;
      tail     <= 1'b0;
    end else begin
      pend_q <= inst_sram_en;
      if (inst_sram_en) begin
        fetch_pc <= inst_sram_addr + 32'd4;
        pend_pc  <= inst_sram_addr;
      end
      if (redirect) begin
        count <= 2'd0;
        head  <= 1'b0;
        tail  <= 1'b0;
      end else begin
        if (enq) tail <= ~tail;
        if (pop) head <= ~head;
        count <= count + {1'b0, enq} - {1'b0, pop};
      end
    end
  end

  // Payload storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (enq) q[tail] <= '{pc: pend_pc, inst: inst_sram_rdata};
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, async-reset and wrap sequences, then random traffic vs a queue model.
module tb_if_stage;

  localparam logic [31:0] RESET_PC  = 32'h1c000000;
  localparam logic [31:0] BUBBLE_PC = 32'h1bfffffc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic        id_allowin = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        fs_to_ds_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  logic [31:0] salt = 32'h0;
  int vectors = 0;
  int miscompares = 0;

  if_stage dut (
    .clk(clk), .reset(reset),
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr), .inst_sram_rdata(inst_sram_rdata),
    .id_allowin(id_allowin), .br_taken(br_taken), .br_target(br_target),
    .fs_to_ds_valid(fs_to_ds_valid), .id_pc(id_pc), .id_inst(id_inst)
  );

  always #5 clk = ~clk;

  // Instruction memory: word content is its address xor salt, one cycle after the request.
  always @(posedge clk) if (inst_sram_en) inst_sram_rdata <= inst_sram_addr ^ salt;

  typedef struct packed {
    logic        allow;
    logic        br;
    logic [31:0] tgt;
    logic        en;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  vec_t tbl [17];

  ent_t        m_q [$];
  logic        m_pend;
  logic [31:0] m_pend_pc;
  logic [31:0] m_fetch;

  function automatic vec_t mk(logic a, logic b, logic [31:0] t, logic e, logic [31:0] ad,
                              logic v, logic [31:0] p);
    vec_t r;
    r.allow = a; r.br = b; r.tgt = t; r.en = e; r.addr = ad; r.vld = v; r.pc = p;
    return r;
  endfunction

  task automatic check(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s.%s: got %h, expected %h", tag, what, act, exp);
    end
  endtask

  // Drive one cycle of inputs, compare mid-cycle, then advance past the next rising edge.
  task automatic apply(input string tag, input logic a, input logic b, input logic [31:0] t,
                       input logic e, input logic [31:0] ad, input logic v,
                       input logic [31:0] p, input logic [31:0] ins);
    id_allowin = a;
    br_taken   = b;
    br_target  = t;
    @(negedge clk);
    check(tag, "en",    {31'b0, inst_sram_en},   {31'b0, e});
    check(tag, "addr",  inst_sram_addr,          ad);
    check(tag, "valid", {31'b0, fs_to_ds_valid}, {31'b0, v});
    check(tag, "pc",    id_pc,                   p);
    check(tag, "inst",  id_inst,                 ins);
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_q.delete();
    m_pend    = 1'b0;
    m_pend_pc = RESET_PC;
    m_fetch   = RESET_PC;
  endtask

  // One model cycle: expectations from the queue contents, then advance the queue for the edge.
  task automatic model_step(input string tag, input logic a, input logic b, input logic [31:0] t);
    logic        v, pop, redir, e;
    logic [31:0] p, ins, ad;
    ent_t        ne;
    int          owed;
    v     = (m_q.size() != 0);
    p     = v ? m_q[0].pc : BUBBLE_PC;
    ins   = v ? m_q[0].inst : 32'h0;
    pop   = v && a;
    redir = pop && b;
    owed  = m_q.size() - int'(pop) + int'(m_pend);
    e     = redir || (owed < 2);
    ad    = redir ? t : m_fetch;
    apply(tag, a, b, t, e, ad, v, p, ins);
    if (redir) m_q.delete();
    else begin
      if (pop) void'(m_q.pop_front());
      if (m_pend) begin
        ne.pc   = m_pend_pc;
        ne.inst = m_pend_pc ^ salt;
        m_q.push_back(ne);
      end
    end
    m_pend = e;
    if (e) begin
      m_pend_pc = ad;
      m_fetch   = ad + 32'd4;
    end
  endtask

  initial begin
    logic        a, b;
    logic [31:0] t;

    tbl[0]  = mk(1, 0, 0,            1, 32'h1c000000, 0, BUBBLE_PC);
    tbl[1]  = mk(1, 0, 0,            1, 32'h1c000004, 0, BUBBLE_PC);
    tbl[2]  = mk(0, 0, 0,            0, 32'h1c000008, 1, 32'h1c000000);
    tbl[3]  = mk(0, 0, 0,            0, 32'h1c000008, 1, 32'h1c000000);
    tbl[4]  = mk(0, 0, 0,            0, 32'h1c000008, 1, 32'h1c000000);
    tbl[5]  = mk(0, 0, 0,            0, 32'h1c000008, 1, 32'h1c000000);
    tbl[6]  = mk(0, 0, 0,            0, 32'h1c000008, 1, 32'h1c000000);
    tbl[7]  = mk(1, 0, 0,            1, 32'h1c000008, 1, 32'h1c000000);
    tbl[8]  = mk(1, 0, 0,            1, 32'h1c00000c, 1, 32'h1c000004);
    tbl[9]  = mk(1, 1, 32'h1c000100, 1, 32'h1c000100, 1, 32'h1c000008);
    tbl[10] = mk(1, 0, 0,            1, 32'h1c000104, 0, BUBBLE_PC);
    tbl[11] = mk(1, 0, 0,            1, 32'h1c000108, 1, 32'h1c000100);
    tbl[12] = mk(0, 1, 32'h1c000200, 0, 32'h1c00010c, 1, 32'h1c000104);
    tbl[13] = mk(0, 1, 32'h1c000200, 0, 32'h1c00010c, 1, 32'h1c000104);
    tbl[14] = mk(1, 1, 32'h1c000200, 1, 32'h1c000200, 1, 32'h1c000104);
    tbl[15] = mk(1, 0, 0,            1, 32'h1c000204, 0, BUBBLE_PC);
    tbl[16] = mk(1, 0, 0,            1, 32'h1c000208, 1, 32'h1c000200);

    // Reset state
    @(negedge clk);
    check("reset", "en",    {31'b0, inst_sram_en},   32'h0);
    check("reset", "valid", {31'b0, fs_to_ds_valid}, 32'h0);
    check("reset", "pc",    id_pc,                   BUBBLE_PC);
    check("reset", "inst",  id_inst,                 32'h0);
    release_reset();

    for (int i = 0; i < 17; i++)
      apply($sformatf("tbl%0d", i), tbl[i].allow, tbl[i].br, tbl[i].tgt, tbl[i].en,
            tbl[i].addr, tbl[i].vld, tbl[i].pc, tbl[i].vld ? tbl[i].pc : 32'h0);

    // Fill the queue, then hit reset mid-cycle
    id_allowin = 1'b0;
    br_taken   = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst", "en",    {31'b0, inst_sram_en},   32'h0);
    check("async_rst", "valid", {31'b0, fs_to_ds_valid}, 32'h0);
    check("async_rst", "pc",    id_pc,                   BUBBLE_PC);
    check("async_rst", "inst",  id_inst,                 32'h0);
    release_reset();

    apply("restart0", 1, 0, 0, 1, 32'h1c000000, 0, BUBBLE_PC, 32'h0);
    apply("restart1", 1, 0, 0, 1, 32'h1c000004, 0, BUBBLE_PC, 32'h0);
    apply("wrap0", 1, 1, 32'hfffffffc, 1, 32'hfffffffc, 1, 32'h1c000000, 32'h1c000000);
    apply("wrap1", 1, 0, 0, 1, 32'h00000000, 0, BUBBLE_PC, 32'h0);
    apply("wrap2", 1, 0, 0, 1, 32'h00000004, 1, 32'hfffffffc, 32'hfffffffc);

    // Random traffic against the queue model
    reset = 1'b1;
    salt  = $urandom;
    release_reset();
    for (int c = 0; c < 600; c++) begin
      a = ($urandom_range(0, 9) < 7);
      b = ($urandom_range(0, 9) < 2);
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      model_step($sformatf("rand%0d", c), a, b, t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
